// File: rtl/npc_sequencer.sv
// Next-PC controller for the fetch stage: sequential fetch, stall hold, redirect buffer, exception entry and eret.
// Define NPC_TARGET_CHECK_EN to build the redirect-target legality check that drives tgt_fault.
module npc_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [31:0] IMEM_LO    = 32'h0000_3000,
    parameter logic [31:0] IMEM_HI    = 32'h0000_6ffc
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] pc,
    input  logic        stall,
    input  logic        br_valid,
    input  logic [31:0] br_target,
    input  logic        exc_req,
    input  logic [31:0] exc_epc,
    input  logic        eret,
    output logic [31:0] npc,
    output logic        flush,
    output logic [31:0] epc,
    output logic        in_handler,
    output logic        tgt_fault
);

    typedef enum logic {
        RUN     = 1'b0,
        HANDLER = 1'b1
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] epc_nxt;
    logic        pend_v, pend_v_nxt;
    logic [31:0] pend_tgt, pend_tgt_nxt;
    logic        redir_sel;
    logic [31:0] redir_tgt;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no branch can infer a latch.
        npc          = pc + 32'd4;
        flush        = 1'b0;
        state_nxt    = state;
        epc_nxt      = epc;
        pend_v_nxt   = pend_v;
        pend_tgt_nxt = pend_tgt;
        redir_sel    = 1'b0;
        redir_tgt    = 32'd0;

        if (!Reset) begin
            npc = RESET_PC;
        end else if (exc_req && state == RUN) begin
            npc        = HANDLER_PC;
            flush      = 1'b1;
            epc_nxt    = exc_epc;
            pend_v_nxt = 1'b0;
            state_nxt  = HANDLER;
        end else if (eret && state == HANDLER && !stall) begin
            npc        = epc;
            flush      = 1'b1;
            pend_v_nxt = 1'b0;
            state_nxt  = RUN;
        end else if (stall) begin
            npc = pc;
            // Only the first redirect seen during a stall is buffered.
            if (br_valid && !pend_v) begin
                pend_v_nxt   = 1'b1;
                pend_tgt_nxt = br_target;
            end
        end else if (pend_v) begin
            npc        = pend_tgt;
            pend_v_nxt = 1'b0;
            redir_sel  = 1'b1;
            redir_tgt  = pend_tgt;
        end else if (br_valid) begin
            npc       = br_target;
            redir_sel = 1'b1;
            redir_tgt = br_target;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; all state here is plain flops, so all of it is reset.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state    <= RUN;
            epc      <= 32'd0;
            pend_v   <= 1'b0;
            pend_tgt <= 32'd0;
        end else begin
            state    <= state_nxt;
            epc      <= epc_nxt;
            pend_v   <= pend_v_nxt;
            pend_tgt <= pend_tgt_nxt;
        end
    end

    assign in_handler = (state == HANDLER);

`ifdef NPC_TARGET_CHECK_EN
    logic tgt_bad;
    assign tgt_bad = (redir_tgt[1:0] != 2'b00) || (redir_tgt < IMEM_LO) || (redir_tgt > IMEM_HI);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            tgt_fault <= 1'b0;
        end else begin
            tgt_fault <= redir_sel && tgt_bad;
        end
    end
`else
    logic unused_check;
    assign unused_check = ^{redir_sel, redir_tgt, IMEM_LO, IMEM_HI};
    assign tgt_fault    = 1'b0;
`endif

endmodule

// File: tb/tb_npc_sequencer.sv
// Self-checking bench for npc_sequencer: directed scenarios plus randomized traffic against a queue-based model.
module tb_npc_sequencer;

    localparam logic [31:0] RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
    localparam logic [31:0] IMEM_LO    = 32'h0000_3000;
    localparam logic [31:0] IMEM_HI    = 32'h0000_6ffc;
`ifdef NPC_TARGET_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] pc, br_target, exc_epc;
    logic        stall, br_valid, exc_req, eret;
    logic [31:0] npc, epc;
    logic        flush, in_handler, tgt_fault;

    int checks   = 0;
    int failures = 0;

    // Reference model: handler flag, saved EPC, redirect buffer as a queue, pending fault flag.
    bit          m_handler;
    logic [31:0] m_epc;
    logic [31:0] pend_q[$];
    bit          m_fault;

    logic [31:0] exp_npc, exp_epc;
    bit          exp_flush, exp_handler, exp_fault;

    npc_sequencer #(
        .RESET_PC  (RESET_PC),
        .HANDLER_PC(HANDLER_PC),
        .IMEM_LO   (IMEM_LO),
        .IMEM_HI   (IMEM_HI)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .pc        (pc),
        .stall     (stall),
        .br_valid  (br_valid),
        .br_target (br_target),
        .exc_req   (exc_req),
        .exc_epc   (exc_epc),
        .eret      (eret),
        .npc       (npc),
        .flush     (flush),
        .epc       (epc),
        .in_handler(in_handler),
        .tgt_fault (tgt_fault)
    );

    always #5 Clk = ~Clk;

    function automatic bit illegal(input logic [31:0] t);
        return (t % 4 != 0) || (t < IMEM_LO) || (t > IMEM_HI);
    endfunction

    // Drives one cycle of inputs after the falling edge, computes expectations and advances the model.
    task automatic step(input logic rst, input logic [31:0] p, input logic st, input logic bv,
                        input logic [31:0] bt, input logic er, input logic [31:0] ee, input logic et);
        bit redirect;
        @(negedge Clk);
        Reset = rst; pc = p; stall = st; br_valid = bv; br_target = bt;
        exc_req = er; exc_epc = ee; eret = et;
        #1;
        if (!rst) begin
            m_handler = 1'b0; m_epc = 32'd0; pend_q.delete(); m_fault = 1'b0;
        end
        exp_epc     = m_epc;
        exp_handler = m_handler;
        exp_fault   = m_fault;
        exp_flush   = 1'b0;
        redirect    = 1'b0;
        if (!rst) begin
            exp_npc = RESET_PC;
        end else if (er && !m_handler) begin
            exp_npc = HANDLER_PC; exp_flush = 1'b1;
            m_epc = ee; m_handler = 1'b1; pend_q.delete();
        end else if (et && m_handler && !st) begin
            exp_npc = m_epc; exp_flush = 1'b1;
            m_handler = 1'b0; pend_q.delete();
        end else if (st) begin
            exp_npc = p;
            if (bv && pend_q.size() == 0) pend_q.push_back(bt);
        end else if (pend_q.size() > 0) begin
            exp_npc = pend_q.pop_front(); redirect = 1'b1;
        end else if (bv) begin
            exp_npc = bt; redirect = 1'b1;
        end else begin
            exp_npc = p + 32'd4;
        end
        m_fault = CHECK_EN && redirect && illegal(exp_npc);
    endtask

    task automatic test_reset();
        step(1'b0, 32'h3000, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checks++; if (npc !== 32'h3000) begin failures++; $display("FAIL reset_npc got=%h exp=%h", npc, 32'h3000); end
        checks++; if (flush !== 1'b0) begin failures++; $display("FAIL reset_flush got=%b exp=0", flush); end
        checks++; if (epc !== 32'h0) begin failures++; $display("FAIL reset_epc got=%h exp=0", epc); end
        checks++; if (in_handler !== 1'b0) begin failures++; $display("FAIL reset_in_handler got=%b exp=0", in_handler); end
        checks++; if (tgt_fault !== 1'b0) begin failures++; $display("FAIL reset_tgt_fault got=%b exp=0", tgt_fault); end
        step(1'b1, 32'h3000, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checks++; if (npc !== 32'h3004) begin failures++; $display("FAIL release_npc got=%h exp=%h", npc, 32'h3004); end
        checks++; if (flush !== 1'b0 || in_handler !== 1'b0) begin failures++; $display("FAIL release_flags flush=%b in_handler=%b exp=0,0", flush, in_handler); end
    endtask

    task automatic test_stall_redirect();
        step(1'b1, 32'h3010, 1'b1, 1'b1, 32'h3100, 1'b0, 32'h0, 1'b0);
        checks++; if (npc !== 32'h3010) begin failures++; $display("FAIL stall_hold1 got=%h exp=%h", npc, 32'h3010); end
        step(1'b1, 32'h3010, 1'b1, 1'b1, 32'h3200, 1'b0, 32'h0, 1'b0);
        checks++; if (npc !== 32'h3010) begin failures++; $display("FAIL stall_hold2 got=%h exp=%h", npc, 32'h3010); end
        step(1'b1, 32'h3010, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checks++; if (npc !== 32'h3010) begin failures++; $display("FAIL stall_hold3 got=%h exp=%h", npc, 32'h3010); end
        step(1'b1, 32'h3010, 1'b0, 1'b1, 32'h3500, 1'b0, 32'h0, 1'b0);
        checks++; if (npc !== 32'h3100) begin failures++; $display("FAIL pend_release got=%h exp=%h", npc, 32'h3100); end
        step(1'b1, 32'h3100, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checks++; if (npc !== 32'h3104) begin failures++; $display("FAIL after_pend got=%h exp=%h", npc, 32'h3104); end
    endtask

    task automatic test_exception();
        step(1'b1, 32'h3030, 1'b1, 1'b1, 32'h3300, 1'b0, 32'h0, 1'b0);
        step(1'b1, 32'h3030, 1'b1, 1'b0, 32'h0, 1'b1, 32'h3020, 1'b0);
        checks++; if (npc !== HANDLER_PC || flush !== 1'b1) begin failures++; $display("FAIL exc_entry npc=%h flush=%b exp=%h,1", npc, flush, HANDLER_PC); end
        step(1'b1, 32'h4180, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checks++; if (epc !== 32'h3020) begin failures++; $display("FAIL exc_epc got=%h exp=%h", epc, 32'h3020); end
        checks++; if (in_handler !== 1'b1) begin failures++; $display("FAIL exc_in_handler got=%b exp=1", in_handler); end
        checks++; if (npc !== 32'h4184) begin failures++; $display("FAIL exc_pend_cleared got=%h exp=%h", npc, 32'h4184); end
    endtask

    task automatic test_handler_eret();
        step(1'b1, 32'h4184, 1'b0, 1'b0, 32'h0, 1'b1, 32'h4184, 1'b0);
        checks++; if (npc !== 32'h4188 || flush !== 1'b0) begin failures++; $display("FAIL nested_exc npc=%h flush=%b exp=%h,0", npc, flush, 32'h4188); end
        step(1'b1, 32'h4188, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        checks++; if (epc !== 32'h3020) begin failures++; $display("FAIL nested_epc got=%h exp=%h", epc, 32'h3020); end
        checks++; if (npc !== 32'h4188 || flush !== 1'b0) begin failures++; $display("FAIL eret_stall1 npc=%h flush=%b exp=%h,0", npc, flush, 32'h4188); end
        step(1'b1, 32'h4188, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        checks++; if (npc !== 32'h4188 || in_handler !== 1'b1) begin failures++; $display("FAIL eret_stall2 npc=%h in_handler=%b exp=%h,1", npc, in_handler, 32'h4188); end
        step(1'b1, 32'h4188, 1'b0, 1'b0, 32'h0, 1'b1, 32'h4444, 1'b1);
        checks++; if (npc !== 32'h3020 || flush !== 1'b1) begin failures++; $display("FAIL eret_go npc=%h flush=%b exp=%h,1", npc, flush, 32'h3020); end
        step(1'b1, 32'h3020, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        checks++; if (in_handler !== 1'b0) begin failures++; $display("FAIL eret_exit got=%b exp=0", in_handler); end
        checks++; if (npc !== 32'h3024 || flush !== 1'b0) begin failures++; $display("FAIL eret_in_run npc=%h flush=%b exp=%h,0", npc, flush, 32'h3024); end
    endtask

    task automatic test_wrap();
        step(1'b1, 32'hffff_fffc, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checks++; if (npc !== 32'h0000_0000) begin failures++; $display("FAIL wrap got=%h exp=0", npc); end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 32'h5000, 1'b0, 1'b0, 32'h0, 1'b1, 32'h5000, 1'b0);
        step(1'b1, 32'h4180, 1'b1, 1'b1, 32'h6000, 1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h4180, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checks++; if (epc !== 32'h0 || in_handler !== 1'b0) begin failures++; $display("FAIL mid_reset epc=%h in_handler=%b exp=0,0", epc, in_handler); end
        checks++; if (npc !== RESET_PC) begin failures++; $display("FAIL mid_reset_npc got=%h exp=%h", npc, RESET_PC); end
        step(1'b1, 32'h3040, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checks++; if (npc !== 32'h3044) begin failures++; $display("FAIL mid_reset_pend got=%h exp=%h", npc, 32'h3044); end
    endtask

    task automatic test_target_check();
        step(1'b1, 32'h3050, 1'b0, 1'b1, 32'h7000, 1'b0, 32'h0, 1'b0);
        checks++; if (npc !== 32'h7000) begin failures++; $display("FAIL tgt_hi_npc got=%h exp=%h", npc, 32'h7000); end
        step(1'b1, 32'h7000, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checks++; if (tgt_fault !== CHECK_EN) begin failures++; $display("FAIL tgt_hi_fault got=%b exp=%b", tgt_fault, CHECK_EN); end
        step(1'b1, 32'h3000, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checks++; if (tgt_fault !== 1'b0) begin failures++; $display("FAIL tgt_one_cycle got=%b exp=0", tgt_fault); end
        step(1'b1, 32'h3004, 1'b0, 1'b1, 32'h3002, 1'b0, 32'h0, 1'b0);
        checks++; if (npc !== 32'h3002) begin failures++; $display("FAIL tgt_mis_npc got=%h exp=%h", npc, 32'h3002); end
        step(1'b1, 32'h3002, 1'b0, 1'b1, 32'h6ffc, 1'b0, 32'h0, 1'b0);
        checks++; if (tgt_fault !== CHECK_EN) begin failures++; $display("FAIL tgt_mis_fault got=%b exp=%b", tgt_fault, CHECK_EN); end
        step(1'b1, 32'h6ffc, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checks++; if (tgt_fault !== 1'b0) begin failures++; $display("FAIL tgt_top_legal got=%b exp=0", tgt_fault); end
    endtask

    task automatic test_random();
        logic [31:0] p, bt, ee;
        for (int i = 0; i < 3000; i++) begin
            p  = ($urandom_range(0, 15) == 0) ? $urandom() : {$urandom_range(32'h2ff0, 32'h7010) & 32'hffff_fffc};
            bt = ($urandom_range(0, 3) == 0) ? $urandom() : $urandom_range(32'h2ff8, 32'h7008);
            ee = $urandom_range(32'h3000, 32'h6ffc);
            step(($urandom_range(0, 199) != 0), p, ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 3), bt,
                 ($urandom_range(0, 99) < 8), ee, ($urandom_range(0, 99) < 15));
            checks++; if (npc !== exp_npc) begin failures++; $display("FAIL rnd_npc cyc=%0d got=%h exp=%h", i, npc, exp_npc); end
            checks++; if (flush !== exp_flush) begin failures++; $display("FAIL rnd_flush cyc=%0d got=%b exp=%b", i, flush, exp_flush); end
            checks++; if (epc !== exp_epc) begin failures++; $display("FAIL rnd_epc cyc=%0d got=%h exp=%h", i, epc, exp_epc); end
            checks++; if (in_handler !== exp_handler) begin failures++; $display("FAIL rnd_in_handler cyc=%0d got=%b exp=%b", i, in_handler, exp_handler); end
            checks++; if (tgt_fault !== exp_fault) begin failures++; $display("FAIL rnd_tgt_fault cyc=%0d got=%b exp=%b", i, tgt_fault, exp_fault); end
        end
    endtask

    initial begin
        Reset = 1'b0; pc = 32'h3000; stall = 1'b0; br_valid = 1'b0; br_target = 32'h0;
        exc_req = 1'b0; exc_epc = 32'h0; eret = 1'b0;
        m_handler = 1'b0; m_epc = 32'h0; m_fault = 1'b0;
        test_reset();
        test_stall_redirect();
        test_exception();
        test_handler_eret();
        test_wrap();
        test_reset_mid();
        test_target_check();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
